machine_ctrl: RTL

MACHINE_CTRL -- requirements
Module: machine_ctrl

---
 rtl/machine_ctrl_pkg.sv | 47 ++++
 rtl/machine_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/machine_ctrl_pkg.sv
// Shared CPU definitions: opcode constants, controller state encodings and
// the strobe bundle. Also used by the ALU for opcode decode.
// MACHINE_CTRL_SINGLE_STEP_EN adds the S_WAIT encoding for single-step builds.
package machine_ctrl_pkg;

   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ANDD = 3'b011;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   typedef enum logic [3:0] {
      S0     = 4'd0,
      S1     = 4'd1,
      S2     = 4'd2,
      S3     = 4'd3,
      S4     = 4'd4,
      S5     = 4'd5,
      S6     = 4'd6,
      S7     = 4'd7,
      S_HALT = 4'd8
`ifdef MACHINE_CTRL_SINGLE_STEP_EN
      , S_WAIT = 4'd9
`endif
   } state_t;

   typedef struct packed {
      logic rd;
      logic wr;
      logic load_ir;
      logic inc_pc;
      logic load_pc;
      logic load_acc;
      logic datactl_ena;
      logic alu_ena;
      logic halt;
   } strobes_t;

   // Instructions that read an operand and route it through the ALU
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
   endfunction

endpackage

// File: rtl/machine_ctrl.sv
// CPU sequencing controller: eight-phase instruction cycle plus HALT.
// Strobes decode from the registered state and the captured opcode only,
// so ena never reaches the outputs combinationally.
// Build option MACHINE_CTRL_SINGLE_STEP_EN: S7 parks in S_WAIT until step=1.
//
// state  | meaning
// S0     | fetch high instruction byte (rd, load_ir)
// S1     | fetch low instruction byte, advance PC
// S2     | idle; opcode captured into op_q at the end
// S3     | HLT -> halt, otherwise advance PC past instruction
// S4     | operand fetch / jump / store setup; zero sampled at end
// S5     | ALU strobe, store write, jump, taken-skip PC advance
// S6     | accumulator load / store hold
// S7     | second PC advance for a taken skip
// S_HALT | halted until rst
// S_WAIT | single-step park (optional build)
module machine_ctrl
   import machine_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
`ifdef MACHINE_CTRL_SINGLE_STEP_EN
   input  logic       step,
`endif
   output logic       rd,
   output logic       wr,
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       datactl_ena,
   output logic       alu_ena,
   output logic       halt
);

   state_t     state;
   state_t     state_next;
   logic [2:0] op_q;
   logic       zero_q;
   strobes_t   dec;

   // State register with opcode and zero-flag capture on the advancing edges
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S0;
         op_q   <= 3'b000;
         zero_q <= 1'b0;
      end else begin
         state <= state_next;
         if (ena && (state == S2)) op_q   <= opcode;
         if (ena && (state == S4)) zero_q <= zero;
      end
   end

   // Next-state: HALT is sticky, dropping ena aborts back to S0
   always_comb begin
      state_next = S0;
      if (state == S_HALT) begin
         state_next = S_HALT;
      end else if (!ena) begin
         state_next = S0;
      end else begin
         case (state)
            S0: state_next = S1;
            S1: state_next = S2;
            S2: state_next = S3;
            S3: state_next = (op_q == OP_HLT) ? S_HALT : S4;
            S4: state_next = S5;
            S5: state_next = S6;
            S6: state_next = S7;
`ifdef MACHINE_CTRL_SINGLE_STEP_EN
            S7:     state_next = S_WAIT;
            S_WAIT: state_next = step ? S0 : S_WAIT;
`else
            S7: state_next = S0;
`endif
            default: state_next = S0;
         endcase
      end
   end

   // Strobe decode from state and captured opcode/zero flag
   always_comb begin
      dec = '0;
      case (state)
         S0: begin
            dec.rd      = 1'b1;
            dec.load_ir = 1'b1;
         end
         S1: begin
            dec.rd      = 1'b1;
            dec.load_ir = 1'b1;
            dec.inc_pc  = 1'b1;
         end
         S3: begin
            if (op_q == OP_HLT) dec.halt   = 1'b1;
            else                dec.inc_pc = 1'b1;
         end
         S4: begin
            if (is_alu_op(op_q))  dec.rd          = 1'b1;
            if (op_q == OP_JMP)   dec.load_pc     = 1'b1;
            if (op_q == OP_STO)   dec.datactl_ena = 1'b1;
         end
         S5: begin
            if (is_alu_op(op_q)) begin
               dec.rd      = 1'b1;
               dec.alu_ena = 1'b1;
            end
            if (op_q == OP_JMP) dec.load_pc = 1'b1;
            if (op_q == OP_STO) begin
               dec.wr          = 1'b1;
               dec.datactl_ena = 1'b1;
            end
            if ((op_q == OP_SKZ) && zero_q) dec.inc_pc = 1'b1;
         end
         S6: begin
            if (is_alu_op(op_q)) begin
               dec.rd       = 1'b1;
               dec.load_acc = 1'b1;
            end
            if (op_q == OP_STO) dec.datactl_ena = 1'b1;
         end
         S7: begin
            if ((op_q == OP_SKZ) && zero_q) dec.inc_pc = 1'b1;
         end
         S_HALT: begin
            dec.halt = 1'b1;
         end
         default: dec = '0;
      endcase
   end

   // Strobes stay quiet while reset is held
   assign rd          = dec.rd          & ~rst;
   assign wr          = dec.wr          & ~rst;
   assign load_ir     = dec.load_ir     & ~rst;
   assign inc_pc      = dec.inc_pc      & ~rst;
   assign load_pc     = dec.load_pc     & ~rst;
   assign load_acc    = dec.load_acc    & ~rst;
   assign datactl_ena = dec.datactl_ena & ~rst;
   assign alu_ena     = dec.alu_ena     & ~rst;
   assign halt        = dec.halt        & ~rst;

endmodule
